// File: rtl/daq_pkg.sv
// Shared types for the ADS1256 sample framing path: frame FSM states,
// the buffered frame entry and the default frame sync byte.
package daq_pkg;

  localparam logic [7:0] SAMPLE_FRAMER_SYNC_DEFAULT = 8'hA5;
  localparam int         FRAME_ENTRY_W              = 32;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SEQ,
    D2,
    D1,
    D0,
    CSUM
  } frame_state_t;

  typedef struct packed {
    logic [7:0]  seq;
    logic [23:0] sample;
  } frame_entry_t;

  function automatic logic [7:0] frame_checksum(input frame_entry_t entry);
    return entry.seq ^ entry.sample[23:16] ^ entry.sample[15:8] ^ entry.sample[7:0];
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered occupancy; full/empty derive from the
// registered count so a pop never frees space for a push in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clock_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sample_framer.sv
// Tags ADS1256 samples with a sequence number, buffers them and emits byte
// frames. Define SAMPLE_FRAMER_CHECKSUM_EN to append the XOR checksum byte.
module sample_framer
  import daq_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] SYNC_BYTE = SAMPLE_FRAMER_SYNC_DEFAULT
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       sample_valid_i,
  input  logic [23:0]                sample_i,
  input  logic                       tx_ready_i,
  output logic                       tx_valid_o,
  output logic [7:0]                 tx_data_o,
  input  logic                       clear_overflow_i,
  output logic                       overflow_o,
  output logic [15:0]                drop_count_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  frame_entry_t push_entry;
  frame_entry_t pop_entry;
  frame_entry_t frame_q;
  frame_state_t state_q;
  logic [7:0]   seq_q;
  logic         tx_valid_q;
  logic [7:0]   tx_data_q;
  logic         overflow_q;
  logic [15:0]  drop_count_q;
  logic [15:0]  drop_count_d;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic         drop;
  logic         tx_fire;

  assign push_entry   = '{seq: seq_q, sample: sample_i};
  assign drop         = sample_valid_i && fifo_full;
  assign fifo_pop     = (state_q == IDLE) && !fifo_empty;
  assign tx_fire      = tx_valid_q && tx_ready_i;
  assign tx_valid_o   = tx_valid_q;
  assign tx_data_o    = tx_data_q;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_count_q;

  sample_fifo #(
    .WIDTH (FRAME_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (sample_valid_i),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (pop_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (level_o)
  );

  // A drop coinciding with a clear restarts the count at one.
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop) begin
      if (clear_overflow_i) begin
        drop_count_d = 16'd1;
      end else if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end else if (clear_overflow_i) begin
      drop_count_d = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      seq_q        <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      if (sample_valid_i) begin
        seq_q <= seq_q + 8'd1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clear_overflow_i) begin
        overflow_q <= 1'b0;
      end
      drop_count_q <= drop_count_d;
    end
  end

  // Each byte state holds its registered byte until the handshake.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            frame_q    <= pop_entry;
            state_q    <= SYNC;
            tx_valid_q <= 1'b1;
            tx_data_q  <= SYNC_BYTE;
          end
        end
        SYNC: begin
          if (tx_fire) begin
            state_q   <= SEQ;
            tx_data_q <= frame_q.seq;
          end
        end
        SEQ: begin
          if (tx_fire) begin
            state_q   <= D2;
            tx_data_q <= frame_q.sample[23:16];
          end
        end
        D2: begin
          if (tx_fire) begin
            state_q   <= D1;
            tx_data_q <= frame_q.sample[15:8];
          end
        end
        D1: begin
          if (tx_fire) begin
            state_q   <= D0;
            tx_data_q <= frame_q.sample[7:0];
          end
        end
        D0: begin
          if (tx_fire) begin
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
            state_q   <= CSUM;
            tx_data_q <= frame_checksum(frame_q);
`else
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
`endif
          end
        end
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
        CSUM: begin
          if (tx_fire) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
          end
        end
`endif
        default: begin
          state_q    <= IDLE;
          tx_valid_q <= 1'b0;
          tx_data_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_framer.sv
// Directed self-checking bench for sample_framer; honours
// SAMPLE_FRAMER_CHECKSUM_EN to pick the expected frame length.
module tb_sample_framer;

   localparam int DEPTH = 16;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
   localparam int FRAME_LEN = 6;
`else
   localparam int FRAME_LEN = 5;
`endif

   logic        clock_i;
   logic        reset_i;
   logic        sampleValid;
   logic [23:0] sampleData;
   logic        txReady;
   logic        txValid;
   logic [7:0]  txData;
   logic        clearOverflow;
   logic        overflowFlag;
   logic [15:0] dropCount;
   logic [$clog2(DEPTH):0] fifoLevel;

   int assertCount = 0;
   int failCount   = 0;

   sample_framer #(
      .DEPTH     (DEPTH),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clock_i          (clock_i),
      .reset_i          (reset_i),
      .sample_valid_i   (sampleValid),
      .sample_i         (sampleData),
      .tx_ready_i       (txReady),
      .tx_valid_o       (txValid),
      .tx_data_o        (txData),
      .clear_overflow_i (clearOverflow),
      .overflow_o       (overflowFlag),
      .drop_count_o     (dropCount),
      .level_o          (fifoLevel)
   );

   // Free-running 10-unit clock; all bench activity happens on the falling edge
   initial begin
      clock_i = 1'b0;
      forever #5 clock_i = ~clock_i;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // One-cycle sample strobe straddling the next rising edge
   task automatic applyStimulus(input logic [23:0] smp);
      sampleData  = smp;
      sampleValid = 1'b1;
      @(negedge clock_i);
      sampleValid = 1'b0;
   endtask

   // Synchronous reset held over two rising edges
   task automatic doReset();
      reset_i = 1'b1;
      repeat (2) @(negedge clock_i);
      reset_i = 1'b0;
   endtask

   function automatic logic [23:0] fillSample(input int k);
      logic [7:0] kb;
      kb = 8'(k);
      return {8'hC0, kb, ~kb};
   endfunction

   // Receives one frame, checking every byte, stall stability and valid hold
   task automatic runFrame(input logic [7:0] seq, input logic [23:0] smp, input bit useBackpressure);
      logic [7:0]  expBytes [6];
      logic [15:0] readyPattern;
      int idx;
      int budget;
      int patIdx;
      bit started;
      expBytes[0] = 8'hA5;
      expBytes[1] = seq;
      expBytes[2] = smp[23:16];
      expBytes[3] = smp[15:8];
      expBytes[4] = smp[7:0];
      expBytes[5] = seq ^ smp[23:16] ^ smp[15:8] ^ smp[7:0];
      readyPattern = 16'b1011_0010_0110_1001;
      idx = 0;
      budget = 0;
      patIdx = 0;
      started = 1'b0;
      while (idx < FRAME_LEN && budget < 400) begin
         txReady = useBackpressure ? readyPattern[patIdx % 16] : 1'b1;
         patIdx++;
         if (started) begin
            checkOutput($sformatf("validHeld_seq%0h", seq), 32'(txValid), 32'd1);
         end
         if (txValid) begin
            started = 1'b1;
            checkOutput($sformatf("seq%0h_byte%0d", seq, idx), 32'(txData), 32'(expBytes[idx]));
            if (txReady) begin
               idx++;
            end
         end
         budget++;
         @(negedge clock_i);
      end
      if (idx < FRAME_LEN) begin
         checkOutput($sformatf("frameTimeout_seq%0h", seq), 32'(idx), 32'(FRAME_LEN));
      end
   endtask

   initial begin
      int idx;
      int budget;
      reset_i       = 1'b1;
      sampleValid   = 1'b0;
      sampleData    = '0;
      txReady       = 1'b0;
      clearOverflow = 1'b0;
      @(negedge clock_i);
      doReset();

      // Reset values
      checkOutput("rstValid", 32'(txValid), 32'd0);
      checkOutput("rstData", 32'(txData), 32'd0);
      checkOutput("rstOverflow", 32'(overflowFlag), 32'd0);
      checkOutput("rstDrops", 32'(dropCount), 32'd0);
      checkOutput("rstLevel", 32'(fifoLevel), 32'd0);

      // Single sample: two-cycle latency to the sync byte
      txReady = 1'b1;
      applyStimulus(24'h123456);
      checkOutput("latLevel1", 32'(fifoLevel), 32'd1);
      checkOutput("latValidEarly", 32'(txValid), 32'd0);
      @(negedge clock_i);
      checkOutput("latValid", 32'(txValid), 32'd1);
      checkOutput("latSync", 32'(txData), 32'hA5);
      checkOutput("latLevel0", 32'(fifoLevel), 32'd0);
      runFrame(8'h00, 24'h123456, 1'b0);

      // Same sample under a stalling consumer
      applyStimulus(24'h123456);
      runFrame(8'h01, 24'h123456, 1'b1);

      // 300 well-spaced samples; sequence wraps through FF to 00
      txReady = 1'b1;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(24'(i * 24'h013579 + 24'h2468AC));
         runFrame(8'(i + 2), 24'(i * 24'h013579 + 24'h2468AC), 1'b0);
      end
      checkOutput("wrapNoDrops", 32'(dropCount), 32'd0);

      // Reset while the D1 byte is on the bus, with a second entry buffered
      txReady = 1'b1;
      applyStimulus(24'h777777);
      applyStimulus(24'h888888);
      idx = 0;
      budget = 0;
      while (idx < 3 && budget < 50) begin
         if (txValid && txReady) idx++;
         budget++;
         @(negedge clock_i);
      end
      checkOutput("d1Reached", 32'(txData), 32'h77);
      checkOutput("levelBeforeReset", 32'(fifoLevel), 32'd1);
      reset_i = 1'b1;
      txReady = 1'b0;
      @(negedge clock_i);
      checkOutput("midResetValid", 32'(txValid), 32'd0);
      checkOutput("midResetLevel", 32'(fifoLevel), 32'd0);
      reset_i = 1'b0;
      txReady = 1'b1;
      applyStimulus(24'h0BEEF0);
      runFrame(8'h00, 24'h0BEEF0, 1'b0);

      // Overflow: framer holds seq 00 in its frame register, FIFO takes 16, 3 drop
      doReset();
      txReady = 1'b0;
      for (int k = 0; k < DEPTH + 4; k++) begin
         applyStimulus(fillSample(k));
      end
      checkOutput("fillLevel", 32'(fifoLevel), 32'(DEPTH));
      checkOutput("fillOverflow", 32'(overflowFlag), 32'd1);
      checkOutput("fillDrops", 32'(dropCount), 32'd3);
      clearOverflow = 1'b1;
      applyStimulus(fillSample(20));
      clearOverflow = 1'b0;
      checkOutput("dropWinsFlag", 32'(overflowFlag), 32'd1);
      checkOutput("dropWinsCount", 32'(dropCount), 32'd1);
      clearOverflow = 1'b1;
      @(negedge clock_i);
      clearOverflow = 1'b0;
      checkOutput("clearFlag", 32'(overflowFlag), 32'd0);
      checkOutput("clearCount", 32'(dropCount), 32'd0);
      txReady = 1'b1;
      for (int k = 0; k <= DEPTH; k++) begin
         runFrame(8'(k), fillSample(k), 1'b0);
      end
      checkOutput("drainedLevel", 32'(fifoLevel), 32'd0);
      applyStimulus(24'h00FACE);
      runFrame(8'h15, 24'h00FACE, 1'b0);

      // Back-to-back frames: one idle cycle after the final handshake
      doReset();
      txReady = 1'b1;
      applyStimulus(24'hABCDEF);
      applyStimulus(24'h13579B);
      runFrame(8'h00, 24'hABCDEF, 1'b0);
      checkOutput("gapValidLow", 32'(txValid), 32'd0);
      @(negedge clock_i);
      checkOutput("gapValidHigh", 32'(txValid), 32'd1);
      checkOutput("gapSync", 32'(txData), 32'hA5);
      runFrame(8'h01, 24'h13579B, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
